// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the pipeline hazard controller: FSM state
//   encodings, default scoreboard depth and the scoreboard entry type.
package pipe_pkg;

  localparam int SB_DEPTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_MEMW  = 2'd2,
    ST_FLUSH = 2'd3
  } pipe_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_entry_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Bundles the ID-stage request, branch/memory status and the pipeline
//   control outputs of pipe_ctrl.
//   master : drives ID/branch/memory status, observes controls (pipeline side)
//   slave  : the controller itself
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       id_dest;
  logic             id_regwrite;
  logic             br_taken;
  logic             mem_busy;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_regwrite,
           br_taken, mem_busy,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze, state,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_regwrite,
           br_taken, mem_busy,
    output pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze, state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//   Tracks destination registers of in-flight writes. Entry 0 is EX, the
//   last entry is WB. Each non-hold cycle shifts toward WB (dropping the WB
//   entry) and loads i_entry into entry 0.
//   Ports: clk, reset (async, active-high), i_hold (freeze contents),
//          i_entry (new EX entry), i_rs/i_rt (lookup registers),
//          o_match_rs/o_match_rt (lookup hits a valid entry).
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_hold,
  input  sb_entry_t  i_entry,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  output logic       o_match_rs,
  output logic       o_match_rt
);

  sb_entry_t r_sb [SB_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) r_sb[i] <= '0;
    end else if (!i_hold) begin
      for (int i = SB_DEPTH - 1; i > 0; i--) r_sb[i] <= r_sb[i-1];
      r_sb[0] <= i_entry;
    end
  end

  always_comb begin
    o_match_rs = 1'b0;
    o_match_rt = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_sb[i].valid && (r_sb[i].dest == i_rs)) o_match_rs = 1'b1;
      if (r_sb[i].valid && (r_sb[i].dest == i_rt)) o_match_rt = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   In-order pipeline hazard controller without forwarding. Classifies each
//   cycle (mem_busy > br_taken > RAW hazard > run), drives the pipeline
//   enables combinationally, and keeps saturating stall/flush counters.
//   Ports: clk, reset (async, active-high), bus (pipe_ctrl_if.slave).
//
//   state | meaning
//   RUN   | previous cycle advanced normally
//   HAZ   | previous cycle stalled ID on a RAW hazard
//   MEMW  | previous cycle froze the pipe for data memory
//   FLUSH | previous cycle squashed younger work on a taken branch
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_state_e      r_state;
  pipe_state_e      w_class;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_match_rs;
  logic             w_match_rt;
  logic             w_hazard;
  logic             w_sb_hold;
  sb_entry_t        w_sb_entry;
  logic             w_pc_we;
  logic             w_ifid_we;
  logic             w_ifid_flush;
  logic             w_idex_bubble;
  logic             w_pipe_freeze;

  pipe_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_hold     (w_sb_hold),
    .i_entry    (w_sb_entry),
    .i_rs       (bus.id_rs),
    .i_rt       (bus.id_rt),
    .o_match_rs (w_match_rs),
    .o_match_rt (w_match_rt)
  );

  // r0 is hardwired zero, so reading it can never be a hazard.
  assign w_hazard = bus.id_valid &&
                    ((bus.id_use_rs && (bus.id_rs != 5'd0) && w_match_rs) ||
                     (bus.id_use_rt && (bus.id_rt != 5'd0) && w_match_rt));

  always_comb begin
    w_class = ST_RUN;
    if (bus.mem_busy)      w_class = ST_MEMW;
    else if (bus.br_taken) w_class = ST_FLUSH;
    else if (w_hazard)     w_class = ST_HAZ;
  end

  // Only a normally issuing instruction enters EX; stalls and flushes push
  // a bubble so older entries keep retiring.
  always_comb begin
    w_sb_hold        = (w_class == ST_MEMW);
    w_sb_entry.valid = 1'b0;
    w_sb_entry.dest  = 5'd0;
    if (w_class == ST_RUN) begin
      w_sb_entry.valid = bus.id_valid && bus.id_regwrite && (bus.id_dest != 5'd0);
      w_sb_entry.dest  = bus.id_dest;
    end
  end

  always_comb begin
    w_pc_we       = 1'b0;
    w_ifid_we     = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_pipe_freeze = 1'b0;
    if (reset) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else begin
      unique case (w_class)
        ST_MEMW:  w_pipe_freeze = 1'b1;
        ST_FLUSH: begin
          w_pc_we       = 1'b1;
          w_ifid_we     = 1'b1;
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
        end
        ST_HAZ:   w_idex_bubble = 1'b1;
        default: begin
          w_pc_we   = 1'b1;
          w_ifid_we = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_class;
      if (((w_class == ST_HAZ) || (w_class == ST_MEMW)) && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((w_class == ST_FLUSH) && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.pc_we       = w_pc_we;
  assign bus.ifid_we     = w_ifid_we;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.pipe_freeze = w_pipe_freeze;
  assign bus.state       = r_state;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed-vector bench for pipe_ctrl (SB_DEPTH=3, CNT_W=4).
//   Control bundle order: {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze}.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_HAZ   = 5'b00010;
  localparam logic [4:0] O_MEMW  = 5'b00001;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_RST   = 5'b00110;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;

  pipe_ctrl_if #(.CNT_W(4)) bus ();

  pipe_ctrl #(.SB_DEPTH(3), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [4:0] outs;
  assign outs = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble, bus.pipe_freeze};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [4:0] dest, input logic rw);
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.id_dest     = dest;
    bus.id_regwrite = rw;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    id_set(0, 0, 0, 0, 0, 0, 0);
    bus.br_taken = 1'b0;
    bus.mem_busy = 1'b0;
    at_neg;
    chk("rst_outs", outs, O_RST);
    chk("rst_stall", bus.stall_cnt, 0);
    tick;
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    id_set(0, 0, 0, 0, 0, 0, 0);
    bus.br_taken = 1'b0;
    bus.mem_busy = 1'b0;

    // reset state
    tick;
    at_neg;
    chk("init_outs", outs, O_RST);
    chk("init_state", bus.state, ST_RUN);
    chk("init_stall", bus.stall_cnt, 0);
    chk("init_flush", bus.flush_cnt, 0);
    tick;
    reset = 1'b0;

    // write r5, then read rs=r5: three stall cycles, issue on the fourth
    id_set(1, 0, 0, 0, 0, 5'd5, 1);
    at_neg; chk("a_write", outs, O_RUN); tick;
    id_set(1, 5'd5, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      at_neg; chk($sformatf("a_stall%0d", k), outs, O_HAZ); tick;
    end
    at_neg;
    chk("a_issue", outs, O_RUN);
    chk("a_state", bus.state, ST_HAZ);
    chk("a_stall_cnt", bus.stall_cnt, 3);
    tick;

    do_reset;

    // r0 writes are never tracked
    id_set(1, 0, 0, 0, 0, 5'd0, 1);
    at_neg; chk("b_write_r0", outs, O_RUN); tick;
    id_set(1, 0, 5'd0, 0, 1, 0, 0);
    at_neg; chk("b_read_rt0", outs, O_RUN); tick;
    id_set(0, 0, 0, 0, 0, 0, 0);
    at_neg; chk("b_stall_cnt", bus.stall_cnt, 0); tick;

    // taken branch overrides a concurrent hazard
    id_set(1, 0, 0, 0, 0, 5'd3, 1);
    at_neg; chk("c_write", outs, O_RUN); tick;
    id_set(1, 5'd3, 0, 1, 0, 0, 0);
    bus.br_taken = 1'b1;
    at_neg; chk("c_flush", outs, O_FLUSH); tick;
    bus.br_taken = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0);
    at_neg;
    chk("c_after", outs, O_RUN);
    chk("c_flush_cnt", bus.flush_cnt, 1);
    chk("c_stall_cnt", bus.stall_cnt, 0);
    chk("c_state", bus.state, ST_FLUSH);
    tick;

    do_reset;

    // mem_busy for 4 cycles in the middle of a stall on r7
    id_set(1, 0, 0, 0, 0, 5'd7, 1);
    at_neg; chk("d_write", outs, O_RUN); tick;
    id_set(1, 5'd7, 0, 1, 0, 0, 0);
    at_neg; chk("d_stall0", outs, O_HAZ); tick;
    bus.mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg;
      chk($sformatf("d_busy%0d", k), outs, O_MEMW);
      if (k == 1) chk("d_state_memw", bus.state, ST_MEMW);
      tick;
    end
    bus.mem_busy = 1'b0;
    for (int k = 1; k < 3; k++) begin
      at_neg; chk($sformatf("d_stall%0d", k), outs, O_HAZ); tick;
    end
    at_neg;
    chk("d_issue", outs, O_RUN);
    chk("d_stall_cnt", bus.stall_cnt, 7);
    tick;

    // asynchronous reset in the middle of a stall on r9
    id_set(1, 0, 0, 0, 0, 5'd9, 1);
    at_neg; chk("e_write", outs, O_RUN); tick;
    id_set(1, 5'd9, 0, 1, 0, 0, 0);
    at_neg; chk("e_stall", outs, O_HAZ);
    #2 reset = 1'b1;
    #1;
    chk("e_rst_outs", outs, O_RST);
    chk("e_rst_stall", bus.stall_cnt, 0);
    chk("e_rst_state", bus.state, ST_RUN);
    tick;
    reset = 1'b0;
    at_neg; chk("e_read_r9", outs, O_RUN); tick;

    do_reset;

    // saturation: self-dependent instruction keeps stalling
    id_set(1, 5'd4, 0, 1, 0, 5'd4, 1);
    for (int k = 0; k < 25; k++) begin
      at_neg;
      chk($sformatf("f_cyc%0d", k), outs, ((k % 4) == 0) ? O_RUN : O_HAZ);
      tick;
    end
    at_neg;
    chk("f_stall_sat", bus.stall_cnt, 15);
    chk("f_flush_cnt", bus.flush_cnt, 0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 3; number of in-flight write entries tracked (EX, MEM, WB).
REQ-002 SHALL have parameter CNT_W, default 16; width of the performance counters.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; one clock domain.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: id_valid  in  1  ID stage holds a valid instruction.
REQ-006 SHALL have ports: id_rs, id_rt  in  5 each  source register numbers of the ID instruction.
REQ-007 SHALL have ports: id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-008 SHALL have ports: id_dest  in  5  destination register; id_regwrite  in  1  ID instruction writes id_dest.
REQ-009 SHALL have ports: br_taken  in  1  branch in EX resolved taken; younger instructions must be squashed.
REQ-010 SHALL have ports: mem_busy  in  1  data memory not ready; whole pipeline must hold.
REQ-011 SHALL have ports: pc_we, ifid_we  out  1 each  PC / IF-ID register write enables.
REQ-012 SHALL have ports: ifid_flush, idex_bubble  out  1 each  clear IF-ID / load NOP into ID-EX.
REQ-013 SHALL have ports: pipe_freeze  out  1  hold ID-EX, EX-MEM, MEM-WB registers.
REQ-014 SHALL have ports: state  out  2  current FSM state.
REQ-015 SHALL have ports: stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-016 SHALL keep a scoreboard of SB_DEPTH entries {valid, dest}: entry 0 = EX, last = WB.
REQ-017 SHALL assert hazard when id_valid and (id_use_rs, id_rs!=0, id_rs equals dest of any valid entry) or the same for rt; no forwarding is assumed.
REQ-018 Priority SHALL be mem_busy > br_taken > hazard > run, evaluated combinationally each cycle (0-cycle latency to outputs).
REQ-019 mem_busy=1: pipe_freeze=1, pc_we=0, ifid_we=0, flush/bubble=0; scoreboard and counters (except stall_cnt) unchanged.
REQ-020 br_taken=1 (mem_busy=0): pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1; scoreboard shifts with invalid entry 0; flush_cnt+1; a coincident hazard is ignored.
REQ-021 hazard (no busy, no branch): pc_we=0, ifid_we=0, idex_bubble=1; scoreboard shifts with invalid entry 0; stall_cnt+1.
REQ-022 run: pc_we=1, ifid_we=1, others 0; scoreboard shifts, entry 0 = {id_valid & id_regwrite & id_dest!=0, id_dest}.
REQ-023 Shift SHALL drop the WB entry; a register written in WB is readable in ID the following cycle.
REQ-024 FSM states RUN=0, HAZ=1, MEMW=2, FLUSH=3; next state is the priority class of the current cycle, registered; state reports the class of the previous cycle.
REQ-025 stall_cnt SHALL count every cycle in hazard or mem_busy class; both counters saturate at all-ones and never wrap.
REQ-026 A stall lasts at most SB_DEPTH consecutive cycles absent mem_busy, since each cycle retires one scoreboard entry.

Reset
REQ-027 While reset=1: scoreboard all invalid, state=RUN, counters 0, pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0.
REQ-028 Reset asserted mid-stall or mid-freeze SHALL discard all tracked entries immediately; first cycle after deassertion behaves as run with empty scoreboard.

Structure
REQ-029 A shared package pipe_pkg SHALL hold state encodings, SB_DEPTH default and the entry type {valid, dest[4:0]}.
REQ-030 The scoreboard SHALL be a sub-module pipe_scoreboard (shift/hold/insert, match outputs for rs and rt); pipe_ctrl holds FSM, priority logic and counters.

Verification
REQ-031 Run: write r5 issued, next ID reads rs=r5 -> 3 stall cycles (pc_we=0, idex_bubble=1), issue on 4th; stall_cnt=3.
REQ-032 r0: id_regwrite with dest=0, next reads rt=0 -> no stall; scoreboard entry 0 invalid.
REQ-033 Branch: br_taken with concurrent rs hazard -> ifid_flush=idex_bubble=1, pc_we=1, stall_cnt unchanged, flush_cnt+1.
REQ-034 Freeze: mem_busy for 4 cycles during a stall on r7 -> scoreboard frozen, pipe_freeze=1, stall resumes after; total stall_cnt = 3+4.
REQ-035 Reset mid-stall on r9 -> outputs at reset values; after release, reading r9 issues without stall.
REQ-036 Saturation: preload stall_cnt to all-ones via forced hazards (CNT_W=4) -> counter holds at 15.
